// File: rtl/bj_ps2_pkg.sv
// rtl/bj_ps2_pkg.sv - shared scan codes, command encodings and parser states
package bj_ps2_pkg;

    localparam logic [7:0] H_MAKE = 8'h33;
    localparam logic [7:0] S_MAKE = 8'h1B;
    localparam logic [7:0] D_MAKE = 8'h23;
    localparam logic [7:0] BREAK  = 8'hF0;
    localparam logic [7:0] EXT    = 8'hE0;
    localparam logic [7:0] BAT_OK = 8'hAA;

    // Command codes double as the bit index into the {D,S,H} held vector
    localparam logic [1:0] CMD_HIT   = 2'd0;
    localparam logic [1:0] CMD_STAND = 2'd1;
    localparam logic [1:0] CMD_DEAL  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_E0   = 2'd1,
        ST_GOT_F0   = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } parse_state_t;

    function automatic logic is_key(input logic [7:0] code);
        return (code == H_MAKE) || (code == S_MAKE) || (code == D_MAKE);
    endfunction

    function automatic logic [1:0] key_cmd(input logic [7:0] code);
        case (code)
            S_MAKE:  return CMD_STAND;
            D_MAKE:  return CMD_DEAL;
            default: return CMD_HIT;
        endcase
    endfunction

endpackage

// File: rtl/bj_cmd_fifo.sv
// rtl/bj_cmd_fifo.sv - show-ahead command queue with explicit occupancy counter
module bj_cmd_fifo #(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [1:0]    push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [1:0]    head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow
);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A pop frees a slot in the same cycle, so a full queue may still accept
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as 0 while empty so the output never shows stale entries
    assign head    = empty ? 2'd0 : mem[rd_ptr];

    // Storage array: written only on accepted pushes that are not flushed
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and drop pulse; flush outranks push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow <= push && !do_push;
        end
    end

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// rtl/ps2_cmd_sequencer.sv - PS/2 set-2 prefix parser, typematic filter and command queue
module ps2_cmd_sequencer
    import bj_ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int PREFIX_TIMEOUT = 100000
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    input  logic                        flush,
    input  logic                        cmd_ready,
    output logic                        cmd_valid,
    output logic [1:0]                  cmd_code,
    output logic [$clog2(FIFO_DEPTH):0] cmd_count,
    output logic [2:0]                  key_held,
    output logic                        overflow,
    output logic                        proto_err,
    output logic                        timeout
);

    localparam int TW = $clog2(PREFIX_TIMEOUT);

    parse_state_t  state;
    parse_state_t  state_n;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_cnt_n;
    logic [2:0]    held_n;
    logic          perr_n;
    logic          tmo_n;
    logic          push;
    logic [1:0]    push_code;
    logic          fifo_empty;
    logic          unused_full;

    // Parser state, prefix timer, held flags and status pulses
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            key_held  <= '0;
            proto_err <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            tmo_cnt   <= tmo_cnt_n;
            key_held  <= held_n;
            proto_err <= perr_n;
            timeout   <= tmo_n;
        end
    end

    // Next-state decode: bytes drive transitions, silence in a prefix state ages the timer
    always_comb begin
        state_n   = state;
        tmo_cnt_n = '0;
        held_n    = key_held;
        perr_n    = 1'b0;
        tmo_n     = 1'b0;
        push      = 1'b0;
        push_code = key_cmd(rx_data);

        if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data == BREAK) begin
                        state_n = ST_GOT_F0;
                    end else if (rx_data == EXT) begin
                        state_n = ST_GOT_E0;
                    end else if (is_key(rx_data)) begin
                        // Only the first make of a press queues a command; repeats are typematic
                        if (!key_held[push_code]) begin
                            held_n[push_code] = 1'b1;
                            push              = 1'b1;
                        end
                    end else if (rx_data == BAT_OK) begin
                        held_n = '0;
                    end
                end
                ST_GOT_F0: begin
                    state_n = ST_IDLE;
                    if (is_key(rx_data)) begin
                        held_n[push_code] = 1'b0;
                    end else if ((rx_data == BREAK) || (rx_data == EXT)) begin
                        perr_n = 1'b1;
                    end
                end
                ST_GOT_E0: begin
                    state_n = (rx_data == BREAK) ? ST_GOT_E0F0 : ST_IDLE;
                end
                ST_GOT_E0F0: begin
                    state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end else if (state != ST_IDLE) begin
            if (tmo_cnt == TW'(PREFIX_TIMEOUT - 1)) begin
                state_n = ST_IDLE;
                tmo_n   = 1'b1;
            end else begin
                tmo_cnt_n = tmo_cnt + TW'(1);
            end
        end
    end

    bj_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLOCK_50),
        .rst      (reset),
        .push     (push),
        .push_data(push_code),
        .pop      (cmd_ready),
        .flush    (flush),
        .head     (cmd_code),
        .full     (unused_full),
        .empty    (fifo_empty),
        .count    (cmd_count),
        .overflow (overflow)
    );

    assign cmd_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// tb/tb_ps2_cmd_sequencer.sv - scoreboard bench with abstract keyboard model
module tb_ps2_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 20;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          flush = 1'b0;
    logic          cmd_ready = 1'b0;
    logic          cmd_valid;
    logic [1:0]    cmd_code;
    logic [CW-1:0] cmd_count;
    logic [2:0]    key_held;
    logic          overflow;
    logic          proto_err;
    logic          timeout;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int ovf_seen = 0;
    int perr_seen = 0;
    int tmo_seen = 0;

    // Model: pending prefix bytes, quiet-cycle age, held keys, command list
    logic [7:0] m_pfx[$];
    int         m_gap;
    logic [2:0] m_held;
    logic [1:0] m_q[$];
    logic       m_ovf, m_perr, m_tmo;
    logic [1:0] sb_q[$];

    always #5 clk = ~clk;

    ps2_cmd_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .PREFIX_TIMEOUT(TMO)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .flush    (flush),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .cmd_count(cmd_count),
        .key_held (key_held),
        .overflow (overflow),
        .proto_err(proto_err),
        .timeout  (timeout)
    );

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int key_code(input logic [7:0] b);
        if (b == 8'h33) return 0;
        if (b == 8'h1B) return 1;
        if (b == 8'h23) return 2;
        return -1;
    endfunction

    function automatic void model_reset();
        m_pfx.delete();
        m_gap  = 0;
        m_held = 3'b000;
        m_q.delete();
        sb_q.delete();
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        m_tmo  = 1'b0;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] b,
                                       input logic rdy, input logic fl);
        int  kc;
        bit  push;
        push   = 1'b0;
        kc     = key_code(b);
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        m_tmo  = 1'b0;
        if (v) begin
            m_gap = 0;
            if (m_pfx.size() == 0) begin
                if (b == 8'hF0 || b == 8'hE0) m_pfx.push_back(b);
                else if (kc >= 0) begin
                    if (!m_held[kc]) begin
                        m_held[kc] = 1'b1;
                        push = 1'b1;
                    end
                end else if (b == 8'hAA) m_held = 3'b000;
            end else if (m_pfx.size() == 1 && m_pfx[0] == 8'hF0) begin
                if (kc >= 0) m_held[kc] = 1'b0;
                else if (b == 8'hF0 || b == 8'hE0) m_perr = 1'b1;
                m_pfx.delete();
            end else if (m_pfx.size() == 1 && b == 8'hF0) begin
                m_pfx.push_back(b);
            end else begin
                m_pfx.delete();
            end
        end else if (m_pfx.size() != 0) begin
            m_gap++;
            if (m_gap == TMO) begin
                m_pfx.delete();
                m_tmo = 1'b1;
                m_gap = 0;
            end
        end
        if (fl) begin
            m_q.delete();
        end else begin
            if (rdy && m_q.size() > 0) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(2'(kc));
                else m_ovf = 1'b1;
            end
        end
    endfunction

    // One clock of stimulus; the model advances at the same edge as the DUT
    task automatic cycle(input logic v, input logic [7:0] b, input logic rdy, input logic fl);
        rx_valid  = v;
        rx_data   = b;
        cmd_ready = rdy;
        flush     = fl;
        if (rdy && m_q.size() > 0) sb_q.push_back(m_q[0]);
        @(posedge clk);
        model_step(v, b, rdy, fl);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_cmd_code"}, cmd_code, 0);
        check({tag, "_cmd_count"}, cmd_count, 0);
        check({tag, "_key_held"}, key_held, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_proto_err"}, proto_err, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    // Monitor: compare outputs against the model, pop the scoreboard on handshakes
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (overflow) ovf_seen++;
            if (proto_err) perr_seen++;
            if (timeout) tmo_seen++;
            check("cmd_valid", cmd_valid, int'(m_q.size() > 0));
            check("cmd_count", cmd_count, m_q.size());
            check("key_held", key_held, m_held);
            check("overflow", overflow, m_ovf);
            check("proto_err", proto_err, m_perr);
            check("timeout", timeout, m_tmo);
            if (cmd_valid && cmd_ready) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL cmd_pop: got code %0d expected no command at %0t", cmd_code, $time);
                end else begin
                    check("cmd_code", cmd_code, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0] tbl [6];
        int base;
        int vp;
        tbl = '{8'h33, 8'h1B, 8'h23, 8'hF0, 8'hE0, 8'hAA};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        chk_en = 1'b1;

        // Single press and pop
        send(8'h33);
        check("t1_valid", cmd_valid, 1);
        check("t1_code", cmd_code, 0);
        check("t1_held", key_held, 3'b001);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_popped", cmd_valid, 0);
        send(8'hF0);
        send(8'h33);

        // Typematic repeats collapse to one command
        send(8'h33); send(8'h33); send(8'h33);
        send(8'hF0); send(8'h33);
        check("t2_count", cmd_count, 1);
        check("t2_held", key_held, 0);
        drain();

        // Five presses into a four-deep queue
        base = ovf_seen;
        foreach (tbl[i]) begin
            if (i < 3) begin
                send(tbl[i]); send(8'hF0); send(tbl[i]);
            end
        end
        send(8'h33); send(8'hF0); send(8'h33);
        send(8'h1B); send(8'hF0); send(8'h1B);
        idle(1);
        check("t3_count", cmd_count, 4);
        check("t3_ovf_pulses", ovf_seen - base, 1);

        // Push and pop together while full
        base = ovf_seen;
        cycle(1'b1, 8'h33, 1'b1, 1'b0);
        check("t5_count", cmd_count, 4);
        check("t5_no_ovf", ovf_seen - base, 0);
        send(8'hF0); send(8'h33);
        cycle(1'b1, 8'h1B, 1'b0, 1'b1);
        check("t5_flush_count", cmd_count, 0);
        send(8'hF0); send(8'h1B);

        // Prefix timeout, then normal parsing resumes
        base = tmo_seen;
        send(8'hE0);
        idle(TMO + 2);
        check("t4_tmo_pulses", tmo_seen - base, 1);
        send(8'h1B);
        check("t4_stand_code", cmd_code, 1);
        send(8'hF0); send(8'h1B);
        drain();
        send(8'hE0); send(8'h33);
        idle(1);
        check("t4_ext_count", cmd_count, 0);
        check("t4_ext_held", key_held, 0);

        // Protocol error, BAT clear, reset while mid-prefix
        base = perr_seen;
        send(8'hF0); send(8'hF0);
        idle(1);
        check("t6_perr_pulses", perr_seen - base, 1);
        send(8'h33);
        check("t6_held", key_held, 3'b001);
        send(8'hAA);
        check("t6_bat", key_held, 0);
        send(8'h23);
        send(8'hF0);
        #2 rst = 1'b1;
        #1;
        chk_en = 1'b0;
        check_all_zero("midreset");
        model_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        send(8'h33);
        check("t6_after_reset", cmd_valid, 1);
        send(8'hF0); send(8'h33);
        drain();

        // Randomized traffic in segments of differing byte density
        for (int seg = 0; seg < 15; seg++) begin
            case (seg % 3)
                0:       vp = 5;
                1:       vp = 40;
                default: vp = 75;
            endcase
            for (int i = 0; i < 200; i++) begin
                logic       v;
                logic [7:0] b;
                v = ($urandom_range(0, 99) < vp);
                b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : tbl[$urandom_range(0, 5)];
                cycle(v, b, ($urandom_range(0, 99) < ((seg % 2) ? 15 : 60)),
                      ($urandom_range(0, 99) < 2));
            end
        end
        drain();
        check("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_sequencer.md
Name: ps2_cmd_sequencer

Overview:
- Sits between PS2_Controller (raw byte + 1-cycle valid) and the blackjack game FSM.
- Parses PS/2 set-2 prefixes (E0, F0) with a state machine and tracks held state for H, S and D.
- Suppresses typematic auto-repeat, so one physical press yields exactly one command.
- Queues commands in a small FIFO that the game FSM drains with a valid/ready handshake, so no keypress is lost while the game is busy.

Parameters:
- FIFO_DEPTH, 4, command queue entries; power of two, 2..16.
- PREFIX_TIMEOUT, 100000, CLOCK_50 cycles allowed between a prefix byte and its follow-up byte (2 ms).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from PS2_Controller.received_data.
- rx_valid  in  1  1-cycle strobe from PS2_Controller.received_data_en.
- flush  in  1  synchronous clear of the command queue (game round change).
- cmd_ready  in  1  game FSM accepts the head command this cycle.
- cmd_valid  out  1  queue not empty.
- cmd_code  out  2  head command: 0=HIT, 1=STAND, 2=DEAL; 3 never produced.
- cmd_count  out  clog2(FIFO_DEPTH)+1  current queue occupancy.
- key_held  out  3  {D,S,H} held flags.
- overflow  out  1  1-cycle pulse: command dropped because the queue was full.
- proto_err  out  1  1-cycle pulse: F0 or E0 received while in GOT_F0.
- timeout  out  1  1-cycle pulse: prefix abandoned.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, timeout counter=0, key_held=0, FIFO empty.
  - All outputs 0; cmd_code=0.
- Parser states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions happen only on cycles with rx_valid=1, except timeout.
- IDLE:
  - F0 -> GOT_F0.
  - E0 -> GOT_E0.
  - 33/1B/23 (H/S/D): if the matching held bit is 0, set it and push the command; if it is 1, drop the byte (typematic).
  - AA (keyboard BAT): clear all key_held.
  - Any other byte: ignored; stay in IDLE.
- GOT_F0:
  - 33/1B/23: clear the matching held bit, no command, -> IDLE.
  - F0 or E0: proto_err pulse, -> IDLE.
  - Other: -> IDLE.
- GOT_E0:
  - F0 -> GOT_E0F0.
  - Any other byte -> IDLE. Extended makes are ignored; E0 33 is not HIT.
- GOT_E0F0: any byte -> IDLE with no held change.
- Timeout:
  - In any non-IDLE state the counter increments each cycle without rx_valid and clears on rx_valid.
  - On reaching PREFIX_TIMEOUT-1: -> IDLE, timeout pulse, counter=0. Held bits are unchanged.
  - In IDLE the counter is held at 0.
- Latency:
  - rx_valid at cycle N -> state, key_held and FIFO write registered at N+1.
  - If the FIFO was empty, cmd_valid=1 and cmd_code valid at N+1 (show-ahead head).
- Handshake:
  - Pop when cmd_valid && cmd_ready; the next head appears the following cycle.
  - cmd_ready with cmd_valid=0 has no effect.
- Full:
  - A push while full with no pop in the same cycle is dropped with an overflow pulse; the held bit is still set.
  - Push and pop in the same cycle while full both succeed and occupancy is unchanged.
  - Push and pop in the same cycle while empty: no pop (cmd_valid was 0), push succeeds.
- Flush:
  - Empties the queue next cycle and has priority over a same-cycle push and pop; the push is discarded silently.
  - Parser state and key_held are unaffected.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is kept as a separate counter, never inferred from pointer equality alone.
- Reset mid-operation (e.g. in GOT_F0 or with a partly full queue) returns to the reset state immediately. Any in-flight byte is lost.

Decomposition:
- Package bj_ps2_pkg:
  - Scan-code constants: H_MAKE=33, S_MAKE=1B, D_MAKE=23, BREAK=F0, EXT=E0, BAT_OK=AA.
  - Command encodings: CMD_HIT=0, CMD_STAND=1, CMD_DEAL=2.
  - Parser state encoding.
- Sub-module bj_cmd_fifo:
  - Parameterised sync FIFO, 2-bit data, show-ahead.
  - Ports: push, pop, flush, full, empty, count, overflow.
- Top level holds the parser FSM, timeout counter and held register.

Test Plan:
- Reset release, feed 33 -> cmd_valid=1 next cycle, cmd_code=0, key_held=001. Assert cmd_ready one cycle -> cmd_valid=0.
- Feed 33,33,33 (typematic) then F0 33 -> exactly one HIT queued (cmd_count=1), key_held=000 after 33 following F0.
- With cmd_ready=0, feed make/break sequences for H, S, D, H, S (5 presses, FIFO_DEPTH=4) -> queue reads 0,1,2,0; one overflow pulse on the 5th press; cmd_count=4.
- Feed E0 then no byte for 100000 cycles -> timeout pulse, state IDLE. Then 1B -> STAND queued. Separately, E0 33 -> nothing queued.
- Queue full (4 entries), present a push and cmd_ready in the same cycle -> cmd_count stays 4, no overflow, head advances. Then assert flush with a simultaneous push -> cmd_count=0 next cycle.
- Feed F0 F0 -> proto_err pulse. Hold H (key_held=001), feed AA -> key_held=000. Assert reset while in GOT_F0 -> all outputs 0 immediately.
